// File: rtl/gpu_pkg.sv
// Shared types and defaults for the pixel compositing path.
package gpu_pkg;

   localparam int PIX_W   = 11;
   localparam int COLOR_W = 16;

   localparam logic [COLOR_W-1:0] DEFAULT_TRANSPARENT = 16'h0000;
   localparam logic [COLOR_W-1:0] DEFAULT_BG_COLOR    = 16'h0000;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      REQ,
      WAIT,
      EMIT
   } seq_state_t;

endpackage

// File: rtl/layer_addr_calc.sv
// Combinational sprite/text read-address and glyph-offset generation from the
// layer header fields of the layer currently being scanned.
module layer_addr_calc #(
   parameter int          ADDR_W        = 24,
   parameter logic [31:0] SPRITE_STRIDE = 32'h1000,
   parameter logic [23:0] TEXT_BASE     = 24'h200000,
   parameter logic [31:0] TEXT_STRIDE   = 32'h100
) (
   input  logic              isText,
   input  logic [7:0]        layerId,
   input  logic [7:0]        spriteFrameIndex,
   input  logic [15:0]       layerWidth,
   input  logic [15:0]       layerHeight,
   input  logic [15:0]       layerX,
   input  logic [15:0]       layerY,
   input  logic [15:0]       characterIndex,
   output logic [ADDR_W-1:0] addr,
   output logic [15:0]       aux
);

   logic [31:0] spriteAddr;
   logic [31:0] textAddr;
   logic [31:0] glyphX;
   logic        unusedBits;

   // Arithmetic is done at 32 bits and wraps before truncation to ADDR_W.
   always_comb begin
      spriteAddr = 32'(layerId) * SPRITE_STRIDE
                 + (32'(spriteFrameIndex) * 32'(layerHeight) + 32'(layerY)) * 32'(layerWidth)
                 + 32'(layerX);
      textAddr   = 32'(TEXT_BASE) + 32'(layerId) * TEXT_STRIDE + 32'(characterIndex);
      glyphX     = 32'(layerX) - 32'(characterIndex) * 32'(layerWidth);
      addr       = isText ? textAddr[ADDR_W-1:0] : spriteAddr[ADDR_W-1:0];
      aux        = isText ? {layerY[7:0], glyphX[7:0]} : 16'h0000;
   end

   assign unusedBits = ^{spriteAddr[31:ADDR_W], textAddr[31:ADDR_W], glyphX[31:8], layerY[15:8]};

endmodule

// File: rtl/layer_scan_sequencer.sv
// Front-to-back layer scan for one pixel: one read per covering layer, first
// opaque colour wins, background when every layer misses or is transparent.
//
//   state | meaning
//   IDLE  | accepting a new pixel coordinate
//   SCAN  | sampling the header of `layer`, looking for a covering layer
//   REQ   | memory read request presented, waiting for the arbiter
//   WAIT  | request accepted, waiting for the colour response
//   EMIT  | composited pixel presented downstream
module layer_scan_sequencer
   import gpu_pkg::*;
#(
   parameter int                  NUM_LAYERS    = 32,
   parameter int                  ADDR_W        = 24,
   parameter logic [31:0]         SPRITE_STRIDE = 32'h1000,
   parameter logic [23:0]         TEXT_BASE     = 24'h200000,
   parameter logic [31:0]         TEXT_STRIDE   = 32'h100,
   parameter logic [COLOR_W-1:0]  TRANSPARENT   = DEFAULT_TRANSPARENT,
   parameter logic [COLOR_W-1:0]  BG_COLOR      = DEFAULT_BG_COLOR,
   localparam int                 LAYER_W       = $clog2(NUM_LAYERS)
) (
   input  logic               clk,
   input  logic               reset,

   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [PIX_W-1:0]   pix_x,
   input  logic [PIX_W-1:0]   pix_y,

   output logic [LAYER_W-1:0] layer,
   output logic [PIX_W-1:0]   pixelX,
   output logic [PIX_W-1:0]   pixelY,
   input  logic               read_ram_en,
   input  logic               read_flash_en,
   input  logic [7:0]         layer_id,
   input  logic [7:0]         sprite_frame_index,
   input  logic [15:0]        layer_width,
   input  logic [15:0]        layer_height,
   input  logic [15:0]        layer_x,
   input  logic [15:0]        layer_y,
   input  logic [15:0]        character_index,

   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [ADDR_W-1:0]  mem_req_addr,
   output logic               mem_req_text,
   output logic [15:0]        mem_req_aux,
   input  logic               mem_rsp_valid,
   input  logic [COLOR_W-1:0] mem_rsp_data,

   output logic               out_valid,
   input  logic               out_ready,
   output logic [PIX_W-1:0]   out_x,
   output logic [PIX_W-1:0]   out_y,
   output logic [COLOR_W-1:0] out_color
);

   seq_state_t        state;
   logic [ADDR_W-1:0] calcAddr;
   logic [15:0]       calcAux;

   layer_addr_calc #(
      .ADDR_W        (ADDR_W),
      .SPRITE_STRIDE (SPRITE_STRIDE),
      .TEXT_BASE     (TEXT_BASE),
      .TEXT_STRIDE   (TEXT_STRIDE)
   ) uAddrCalc (
      .isText           (read_flash_en),
      .layerId          (layer_id),
      .spriteFrameIndex (sprite_frame_index),
      .layerWidth       (layer_width),
      .layerHeight      (layer_height),
      .layerX           (layer_x),
      .layerY           (layer_y),
      .characterIndex   (character_index),
      .addr             (calcAddr),
      .aux              (calcAux)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pix_ready     <= 1'b1;
         layer         <= '0;
         pixelX        <= '0;
         pixelY        <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_text  <= 1'b0;
         mem_req_aux   <= '0;
         out_valid     <= 1'b0;
         out_x         <= '0;
         out_y         <= '0;
         out_color     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pix_valid) begin
                  pix_ready <= 1'b0;
                  pixelX    <= pix_x;
                  pixelY    <= pix_y;
                  out_x     <= pix_x;
                  out_y     <= pix_y;
                  layer     <= LAYER_W'(NUM_LAYERS - 1);
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (read_ram_en) begin
                  mem_req_addr  <= calcAddr;
                  mem_req_text  <= read_flash_en;
                  mem_req_aux   <= calcAux;
                  mem_req_valid <= 1'b1;
                  state         <= REQ;
               end else if (layer != '0) begin
                  layer <= layer - LAYER_W'(1);
               end else begin
                  out_color <= BG_COLOR;
                  out_valid <= 1'b1;
                  state     <= EMIT;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               // Responses arriving in any other state are deliberately dropped.
               if (mem_rsp_valid) begin
                  if (mem_rsp_data != TRANSPARENT) begin
                     out_color <= mem_rsp_data;
                     out_valid <= 1'b1;
                     state     <= EMIT;
                  end else if (layer != '0) begin
                     layer <= layer - LAYER_W'(1);
                     state <= SCAN;
                  end else begin
                     out_color <= BG_COLOR;
                     out_valid <= 1'b1;
                     state     <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  pix_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
